// File: rtl/mem_bus_bridge_pkg.sv
// Shared types and fault bit positions for the memory bus bridge.
package mem_bus_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_ADDR,
        ST_RESP,
        ST_DONE
    } mem_bridge_state_t;

    localparam int FAULT_W        = 4;
    localparam int FAULT_MISALIGN = 0;
    localparam int FAULT_TIMEOUT  = 1;
    localparam int FAULT_BUSERR   = 2;
    localparam int FAULT_PROTO    = 3;

endpackage

// File: rtl/mem_bus_bridge_timeout.sv
// Transaction watchdog: clears before the bus phase, counts ADDR/RESP cycles,
// flags expiry on the cycle whose count completes TIMEOUT cycles.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT > 0) begin : g_ctr
            localparam int CNT_W = $clog2(TIMEOUT + 1);
            localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clear) begin
                    cnt_d = '0;
                end else if (enable) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            // >= so a handshake that wins on the last cycle still times out in RESP
            assign expired = enable && !clear && (cnt_q >= LAST);
        end else begin : g_off
            logic unused_ctr;
            assign unused_ctr = ^{clk, rst_n, clear, enable};
            assign expired    = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/mem_bus_bridge.sv
// Turns single-cycle control pulses plus MAR/MDR into one valid/ready word-bus
// transaction, returning read data and a one-cycle mem_resp.
module mem_bus_bridge
    import mem_bus_bridge_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [ADDR_W-1:0]   mar,
    input  logic [DATA_W-1:0]   mdr,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_resp,
    output logic                bus_valid,
    input  logic                bus_ready,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_wstrb,
    input  logic                bus_rvalid,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_err,
    output logic [FAULT_W-1:0]  fault,
    input  logic                fault_clr
);

    // state   | meaning
    // IDLE    | waiting for a mem_read/mem_write pulse
    // CAPTURE | MAR/MDR settle; latch address/data, check alignment
    // ADDR    | bus_valid high until bus_ready
    // RESP    | waiting for bus_rvalid
    // DONE    | one-cycle mem_resp

    mem_bridge_state_t  state_q, state_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]  bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0]  mem_rdata_q, mem_rdata_d;
    logic [FAULT_W-1:0] fault_q, fault_d;
    logic [FAULT_W-1:0] fault_set;
    logic               req;
    logic               tmo_expired;

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_q == ST_CAPTURE),
        .enable  ((state_q == ST_ADDR) || (state_q == ST_RESP)),
        .expired (tmo_expired)
    );

    assign req = mem_read | mem_write;

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        mem_rdata_d = mem_rdata_q;
        fault_set   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d    = mem_write;
                    state_d = ST_CAPTURE;
                    fault_set[FAULT_PROTO] = mem_read & mem_write;
                end
            end
            ST_CAPTURE: begin
                bus_addr_d  = {mar[ADDR_W-1:2], 2'b00};
                bus_wdata_d = mdr;
                if (mar[1:0] != 2'b00) begin
                    fault_set[FAULT_MISALIGN] = 1'b1;
                    if (!we_q) begin
                        mem_rdata_d = '0;
                    end
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (bus_ready) begin
                    state_d = ST_RESP;
                end else if (tmo_expired) begin
                    fault_set[FAULT_TIMEOUT] = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_RESP: begin
                if (bus_rvalid) begin
                    if (!we_q) begin
                        mem_rdata_d = bus_rdata;
                    end
                    fault_set[FAULT_BUSERR] = bus_err;
                    state_d = ST_DONE;
                end else if (tmo_expired) begin
                    fault_set[FAULT_TIMEOUT] = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_q != ST_IDLE) && req) begin
            fault_set[FAULT_PROTO] = 1'b1;
        end

        // a set event in the clearing cycle survives the clear
        fault_d = (fault_clr ? '0 : fault_q) | fault_set;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            mem_rdata_q <= '0;
            fault_q     <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            mem_rdata_q <= mem_rdata_d;
            fault_q     <= fault_d;
        end
    end

    assign bus_valid = (state_q == ST_ADDR);
    assign mem_resp  = (state_q == ST_DONE);
    assign bus_we    = we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wstrb = '1;
    assign mem_rdata = mem_rdata_q;
    assign fault     = fault_q;

endmodule
